ssp_reg_master: RTL and testbench
=================================

SSP_REG_MASTER -- requirements
Module: ssp_reg_master

Interface
REQ-001 Parameter ACC_CYC, default 2, number of cycles SSP_SSEL is held asserted in ACCESS (legal 1..15).
REQ-002 Parameter RD_DLY, default 2, number of extra cycles before SSP_DO is sampled on a read (legal 0..15).
REQ-003 Parameter GAP_CYC, default 1, number of idle cycles between transactions (legal 0..15).
REQ-004 Clk  input  1  single clock; all state is updated on posedge Clk.
REQ-005 Rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  master can accept a request.
REQ-008 req_wnr  input  1  1 = write, 0 = read.
REQ-009 req_ra  input  3  SSP register address (UCR=0, USR=1, RDR=2, TDR=3, SPR=4).
REQ-010 req_wdata  input  12  write data.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  response consumed.
REQ-013 rsp_rdata  output  12  read data (0 for writes).
REQ-014 rsp_wnr  output  1  echo of the request type.
REQ-015 SSP_SSEL / SSP_EOC  output  1 each  SSP select and end-of-cycle strobe.
REQ-016 SSP_RA  output  3; SSP_WnR  output  1; SSP_DI  output  12  SSP address, direction and write data.
REQ-017 SSP_DO  input  12  SSP read data from the slave.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, SETUP, ACCESS, WAIT, RESP and GAP.
REQ-020 IDLE: req_ready=1; on req_valid&&req_ready, latch wnr/ra/wdata and go to SETUP on the next cycle.
REQ-021 SETUP (1 cycle): SSP_RA/SSP_WnR/SSP_DI driven from the latched values; SSP_SSEL=0; SSP_EOC=0.
REQ-022 ACCESS (ACC_CYC cycles): SSP_SSEL=1; SSP_EOC=1 on the final ACCESS cycle only.
REQ-023 After ACCESS, a write SHALL go to RESP; a read SHALL go to WAIT, or go directly to RESP if RD_DLY=0.
REQ-024 WAIT (RD_DLY cycles): SSP_SSEL=1, SSP_EOC=0; rsp_rdata captures SSP_DO at the clock edge that ends the last WAIT cycle.
REQ-025 When RD_DLY=0, rsp_rdata SHALL capture SSP_DO at the edge ending the last ACCESS cycle.
REQ-026 RESP: SSP_SSEL=0, rsp_valid=1; rsp_valid and rsp_rdata SHALL be held stable until rsp_ready=1.
REQ-027 Leaving RESP: go to GAP when GAP_CYC>0, otherwise to IDLE.
REQ-028 GAP (GAP_CYC cycles): all SSP strobes low, then return to IDLE.
REQ-029 If rsp_ready is already high on RESP entry, rsp_valid SHALL last exactly one cycle.
REQ-030 SSP_RA, SSP_WnR and SSP_DI SHALL hold their values from SETUP through the end of RESP.
REQ-031 No new request SHALL be accepted while busy=1; req_ready=0 outside IDLE.
REQ-032 A single 4-bit down-counter SHALL be loaded with N-1 on entry to each timed state and exit that state at 0.
REQ-033 Latency for a write with defaults: request acceptance to rsp_valid is 4 cycles. For a read with defaults it is 6 cycles.
REQ-034 With the default parameters, back-to-back write throughput is one transaction per 6 cycles.

Reset
REQ-035 While Rst_n=0, all outputs SHALL go to their reset values asynchronously:
- state = IDLE, counter = 0
- SSP_SSEL = 0, SSP_EOC = 0, SSP_RA = 0, SSP_WnR = 0, SSP_DI = 0
- rsp_valid = 0, rsp_rdata = 0, rsp_wnr = 0, busy = 0
- req_ready = 0 (forced low during reset)
REQ-036 Asserting reset mid-transaction SHALL abort the transaction with no response produced.
REQ-037 req_ready SHALL be 1 on the first cycle after Rst_n deasserts.

Structure
REQ-038 Package ssp_pkg SHALL hold:
- the register address constants UCR/USR/RDR/TDR/SPR;
- the READ/WRITE constants;
- the 12-bit register reset values (all 0);
- the FSM state enum.
REQ-039 The timed-state counter SHALL be implemented as the sub-module ssp_cyc_counter (load, decrement, zero flag); no other sub-modules.

Verification
REQ-040 Write RA=UCR, data=12'hDED (defaults): SSEL high for 2 cycles, EOC high only on the 2nd, and DI=12'hDED throughout; rsp_valid is high 4 cycles after acceptance.
REQ-041 Read RA=UCR with the slave returning 12'hDED: rsp_rdata=12'hDED and rsp_wnr=0; rsp_valid is high 6 cycles after acceptance.
REQ-042 After reset, read UCR/USR/RDR/TDR/SPR in turn: each rsp_rdata=12'h000, and consecutive SETUP states are separated by at least GAP_CYC idle cycles.
REQ-043 Hold rsp_ready=0 for 5 cycles in RESP: rsp_valid and rsp_rdata stay stable, and a req_valid pulse during this time is not accepted.
REQ-044 Drop Rst_n during the 2nd ACCESS cycle: SSEL, EOC, busy and rsp_valid go to 0 immediately, and no response is produced.
REQ-045 With ACC_CYC=1, RD_DLY=0, GAP_CYC=0: the read response arrives 3 cycles after acceptance, and a back-to-back request is accepted the cycle after RESP.

Source files
------------

// File: rtl/ssp_pkg.sv
// Shared definitions for the SSP register master: slave register map,
// transfer direction encoding, register reset values and FSM states.
package ssp_pkg;

    localparam logic [2:0] UCR = 3'd0;
    localparam logic [2:0] USR = 3'd1;
    localparam logic [2:0] RDR = 3'd2;
    localparam logic [2:0] TDR = 3'd3;
    localparam logic [2:0] SPR = 3'd4;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    localparam logic [11:0] UCR_RST = 12'h000;
    localparam logic [11:0] USR_RST = 12'h000;
    localparam logic [11:0] RDR_RST = 12'h000;
    localparam logic [11:0] TDR_RST = 12'h000;
    localparam logic [11:0] SPR_RST = 12'h000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_WAIT,
        ST_RESP,
        ST_GAP
    } ssp_state_e;

    // Down-counter preload for a state lasting n cycles; exit happens at zero.
    function automatic logic [3:0] cyc_load(input int n);
        return (n > 0) ? 4'(n - 1) : 4'd0;
    endfunction

endpackage

// File: rtl/ssp_cyc_counter.sv
// 4-bit down-counter timing the ACCESS, WAIT and GAP states.
module ssp_cyc_counter (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [3:0] r_cnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/ssp_reg_master.sv
// Request/response front end that sequences single register accesses on the SSP bus.
//   state  | meaning
//   IDLE   | waiting for a request, req_ready high
//   SETUP  | address/direction/data presented, select still low
//   ACCESS | select high ACC_CYC cycles, EOC on the last one
//   WAIT   | read only: select held RD_DLY cycles before SSP_DO is sampled
//   RESP   | rsp_valid held until rsp_ready
//   GAP    | GAP_CYC quiet cycles before the next request
module ssp_reg_master
    import ssp_pkg::*;
#(
    parameter int ACC_CYC = 2,
    parameter int RD_DLY  = 2,
    parameter int GAP_CYC = 1
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wnr,
    input  logic [2:0]  req_ra,
    input  logic [11:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [11:0] rsp_rdata,
    output logic        rsp_wnr,
    output logic        SSP_SSEL,
    output logic        SSP_EOC,
    output logic [2:0]  SSP_RA,
    output logic        SSP_WnR,
    output logic [11:0] SSP_DI,
    input  logic [11:0] SSP_DO,
    output logic        busy
);

    localparam logic HAS_WAIT = (RD_DLY > 0);
    localparam logic HAS_GAP  = (GAP_CYC > 0);

    ssp_state_e  r_state;
    ssp_state_e  w_next;
    logic        r_wnr;
    logic [2:0]  r_ra;
    logic [11:0] r_wdata;
    logic [11:0] r_rdata;
    logic        w_load;
    logic [3:0]  w_load_val;
    logic        w_dec;
    logic        w_zero;
    logic        w_accept;
    logic        w_acc_last;
    logic        w_wait_last;

    ssp_cyc_counter u_cyc_counter (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    assign w_accept    = (r_state == ST_IDLE) && req_valid;
    assign w_acc_last  = (r_state == ST_ACCESS) && w_zero;
    assign w_wait_last = (r_state == ST_WAIT) && w_zero;
    assign w_dec       = (r_state == ST_ACCESS) || (r_state == ST_WAIT) || (r_state == ST_GAP);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = 4'd0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_next     = ST_ACCESS;
                w_load     = 1'b1;
                w_load_val = cyc_load(ACC_CYC);
            end
            ST_ACCESS: begin
                if (w_zero) begin
                    if ((r_wnr == WRITE) || !HAS_WAIT) begin
                        w_next = ST_RESP;
                    end else begin
                        w_next     = ST_WAIT;
                        w_load     = 1'b1;
                        w_load_val = cyc_load(RD_DLY);
                    end
                end
            end
            ST_WAIT: begin
                if (w_zero) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    if (HAS_GAP) begin
                        w_next     = ST_GAP;
                        w_load     = 1'b1;
                        w_load_val = cyc_load(GAP_CYC);
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (w_zero) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Request fields stay latched until the next acceptance, so the SSP bus
    // is stable from SETUP through RESP without extra hold logic.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_wnr   <= READ;
            r_ra    <= UCR;
            r_wdata <= UCR_RST;
        end else if (w_accept) begin
            r_wnr   <= req_wnr;
            r_ra    <= req_ra;
            r_wdata <= req_wdata;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rdata <= 12'h000;
        end else if (w_acc_last) begin
            if (r_wnr == WRITE) begin
                r_rdata <= 12'h000;
            end else if (!HAS_WAIT) begin
                r_rdata <= SSP_DO;
            end
        end else if (w_wait_last) begin
            r_rdata <= SSP_DO;
        end
    end

    // Gated with Rst_n so the handshake is closed while reset is held.
    assign req_ready = (r_state == ST_IDLE) && Rst_n;
    assign busy      = (r_state != ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_wnr   = r_wnr;
    assign SSP_SSEL  = (r_state == ST_ACCESS) || (r_state == ST_WAIT);
    assign SSP_EOC   = w_acc_last;
    assign SSP_RA    = r_ra;
    assign SSP_WnR   = r_wnr;
    assign SSP_DI    = r_wdata;

endmodule

// File: tb/tb_ssp_reg_master.sv
// Randomized scoreboard bench for ssp_reg_master with an SSP slave model,
// plus a second instance exercising the minimum-latency parameter set.
module tb_ssp_reg_master;
    import ssp_pkg::*;

    localparam int ACC = 2;
    localparam int RD  = 2;

    typedef struct {
        logic        wnr;
        logic [11:0] rdata;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_wnr;
    logic [2:0]  req_ra;
    logic [11:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_wnr;
    logic [11:0] rsp_rdata;
    logic        ssp_ssel, ssp_eoc, ssp_wnr_o;
    logic [2:0]  ssp_ra;
    logic [11:0] ssp_di, ssp_do;
    logic        busy;

    logic        rst_f, req_valid_f, req_ready_f, req_wnr_f;
    logic [2:0]  req_ra_f;
    logic [11:0] req_wdata_f;
    logic        rsp_valid_f, rsp_ready_f, rsp_wnr_f;
    logic [11:0] rsp_rdata_f;
    logic        ssel_f, eoc_f, wnr_f;
    logic [2:0]  ra_f;
    logic [11:0] di_f, do_f;
    logic        busy_f;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int n_issued = 0, n_resp = 0, n_aborted = 0;
    int last_acc = 0;
    exp_t sb[$];
    logic [11:0] model_mem [0:7] = '{UCR_RST, USR_RST, RDR_RST, TDR_RST, SPR_RST,
                                     12'h000, 12'h000, 12'h000};
    logic [11:0] slave_mem [0:7] = '{default: 12'h000};
    int          sel_cnt;
    logic        cur_wnr;
    logic [2:0]  cur_ra;
    logic [11:0] cur_wd;
    bit          force_rdy = 1'b1;
    bit          rdy_val = 1'b1;

    ssp_reg_master u_dut (
        .Clk(clk), .Rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wnr(req_wnr),
        .req_ra(req_ra), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_wnr(rsp_wnr),
        .SSP_SSEL(ssp_ssel), .SSP_EOC(ssp_eoc), .SSP_RA(ssp_ra), .SSP_WnR(ssp_wnr_o),
        .SSP_DI(ssp_di), .SSP_DO(ssp_do), .busy(busy)
    );

    ssp_reg_master #(.ACC_CYC(1), .RD_DLY(0), .GAP_CYC(0)) u_dut_fast (
        .Clk(clk), .Rst_n(rst_f),
        .req_valid(req_valid_f), .req_ready(req_ready_f), .req_wnr(req_wnr_f),
        .req_ra(req_ra_f), .req_wdata(req_wdata_f),
        .rsp_valid(rsp_valid_f), .rsp_ready(rsp_ready_f), .rsp_rdata(rsp_rdata_f), .rsp_wnr(rsp_wnr_f),
        .SSP_SSEL(ssel_f), .SSP_EOC(eoc_f), .SSP_RA(ra_f), .SSP_WnR(wnr_f),
        .SSP_DI(di_f), .SSP_DO(do_f), .busy(busy_f)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Slave: read data is only valid in the last select cycle, so early or
    // late sampling shows up as 12'hBAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sel_cnt <= 0;
        else        sel_cnt <= ssp_ssel ? sel_cnt + 1 : 0;
    end

    always_ff @(posedge clk) begin
        if (rst_n && ssp_ssel && ssp_eoc && ssp_wnr_o) slave_mem[ssp_ra] <= ssp_di;
    end

    assign ssp_do = (ssp_ssel && sel_cnt == ACC + RD - 1) ? slave_mem[ssp_ra] : 12'hBAD;
    assign do_f   = ssel_f ? 12'h5A5 : 12'h000;

    initial forever begin
        @(posedge clk);
        #1;
        rsp_ready = force_rdy ? rdy_val : ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    initial begin : monitor
        bit          prev_stall = 0;
        bit          prev_valid = 0;
        logic [11:0] prev_rdata = 0;
        logic        prev_wnr = 0;
        int          mon_len = 0;
        int          first_cyc = 0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 0; prev_valid = 0; mon_len = 0;
            end else begin
                if (prev_stall)
                    chk(rsp_valid && rsp_rdata == prev_rdata && rsp_wnr == prev_wnr,
                        "rsp_hold", {rsp_valid, rsp_rdata}, {1'b1, prev_rdata});
                chk(busy == !req_ready, "busy_vs_ready", busy, !req_ready);
                if (ssp_ssel) begin
                    chk(ssp_eoc == (mon_len == ACC - 1), "eoc_pos", ssp_eoc, mon_len == ACC - 1);
                    mon_len++;
                end else begin
                    chk(!ssp_eoc, "eoc_no_sel", ssp_eoc, 0);
                    if (mon_len != 0)
                        chk(mon_len == (cur_wnr ? ACC : ACC + RD), "sel_len", mon_len,
                            cur_wnr ? ACC : ACC + RD);
                    mon_len = 0;
                end
                if (ssp_ssel || rsp_valid) begin
                    chk(ssp_ra == cur_ra && ssp_wnr_o == cur_wnr, "bus_addr", {ssp_wnr_o, ssp_ra},
                        {cur_wnr, cur_ra});
                    if (cur_wnr) chk(ssp_di == cur_wd, "bus_di", ssp_di, cur_wd);
                end
                if (rsp_valid && !prev_valid) first_cyc = cyc;
                if (rsp_valid && rsp_ready) begin
                    n_resp++;
                    if (sb.size() == 0) begin
                        chk(0, "unexpected_rsp", rsp_rdata, 0);
                    end else begin
                        e = sb.pop_front();
                        chk(rsp_wnr == e.wnr, "rsp_wnr", rsp_wnr, e.wnr);
                        chk(rsp_rdata == e.rdata, "rsp_rdata", rsp_rdata, e.rdata);
                        chk(first_cyc - e.acc == (e.wnr ? 4 : 6), "rsp_latency",
                            first_cyc - e.acc, e.wnr ? 4 : 6);
                    end
                end
                prev_valid = rsp_valid;
                prev_stall = rsp_valid && !rsp_ready;
                prev_rdata = rsp_rdata;
                prev_wnr   = rsp_wnr;
            end
        end
    end

    // Called at a negedge; returns at the negedge of the SETUP cycle.
    task automatic send(input logic wnr, input logic [2:0] ra, input logic [11:0] wd);
        int   b = 0;
        exp_t e;
        req_wnr = wnr; req_ra = ra; req_wdata = wd; req_valid = 1'b1;
        while (!req_ready && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (!req_ready) begin
            chk(0, "req_timeout", b, 200);
        end else begin
            e.wnr   = wnr;
            e.rdata = wnr ? 12'h000 : model_mem[ra];
            e.acc   = cyc;
            if (wnr) model_mem[ra] = wd;
            sb.push_back(e);
            cur_wnr = wnr; cur_ra = ra; cur_wd = wd;
            last_acc = cyc;
            n_issued++;
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int b = 0;
        while ((sb.size() != 0 || busy) && b < 300) begin
            @(negedge clk);
            b++;
        end
        chk(b < 300, "drain_timeout", b, 300);
    endtask

    task automatic fast_test();
        int b = 0;
        int k;
        rsp_ready_f = 1'b1; req_wnr_f = READ; req_ra_f = RDR; req_wdata_f = 12'h000;
        req_valid_f = 1'b1;
        while (!req_ready_f && b < 20) begin @(negedge clk); b++; end
        k = cyc;
        @(negedge clk);
        b = 0;
        while (!rsp_valid_f && b < 20) begin @(negedge clk); b++; end
        chk(rsp_valid_f, "fast_rsp_seen", rsp_valid_f, 1);
        chk(cyc - k == 3, "fast_rd_latency", cyc - k, 3);
        chk(rsp_rdata_f == 12'h5A5 && rsp_wnr_f == READ, "fast_rdata", {rsp_wnr_f, rsp_rdata_f},
            {READ, 12'h5A5});
        b = 0;
        @(negedge clk);
        while (!req_ready_f && b < 20) begin @(negedge clk); b++; end
        chk(cyc - k == 4, "fast_b2b_accept", cyc - k, 4);
        @(negedge clk);
        req_valid_f = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int   prev;
        logic [2:0] regs [0:4];
        regs = '{UCR, USR, RDR, TDR, SPR};
        rst_n = 1'b0; rst_f = 1'b0;
        req_valid = 0; req_wnr = 0; req_ra = 0; req_wdata = 0;
        req_valid_f = 0; req_wnr_f = 0; req_ra_f = 0; req_wdata_f = 0; rsp_ready_f = 0;
        cur_wnr = 0; cur_ra = 0; cur_wd = 0;
        repeat (3) @(negedge clk);
        chk({req_ready, busy, ssp_ssel, ssp_eoc, rsp_valid, rsp_wnr, ssp_wnr_o} == 7'd0,
            "reset_ctrl", {req_ready, busy, ssp_ssel, ssp_eoc, rsp_valid, rsp_wnr, ssp_wnr_o}, 0);
        chk({rsp_rdata, ssp_ra, ssp_di} == 27'd0, "reset_data", {rsp_rdata, ssp_ra, ssp_di}, 0);
        rst_n = 1'b1; rst_f = 1'b1;
        #1;
        chk(req_ready == 1'b1, "ready_after_rst", req_ready, 1);

        // Reads of every register right after reset, back to back.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            send(READ, regs[i], 12'h000);
            if (i > 0) chk(last_acc - prev == 8, "rd_b2b_interval", last_acc - prev, 8);
            prev = last_acc;
        end
        drain();

        @(negedge clk);
        send(WRITE, UCR, 12'hDED);
        drain();
        @(negedge clk);
        send(READ, UCR, 12'h000);
        drain();

        // Back-to-back writes: one per 6 cycles.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            send(WRITE, TDR, 12'($urandom));
            if (i > 0) chk(last_acc - prev == 6, "wr_b2b_interval", last_acc - prev, 6);
            prev = last_acc;
        end
        drain();

        // Stall in RESP with a request pulse that must be ignored.
        rdy_val = 1'b0;
        @(negedge clk);
        send(READ, TDR, 12'h000);
        begin
            int b = 0;
            while (!rsp_valid && b < 20) begin @(negedge clk); b++; end
        end
        for (int i = 0; i < 5; i++) begin
            chk(rsp_valid && !req_ready, "stall_valid", {rsp_valid, req_ready}, 2'b10);
            req_valid = (i == 2);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rdy_val = 1'b1;
        drain();
        repeat (10) @(negedge clk);

        force_rdy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(logic'($urandom_range(0, 1)), 3'($urandom_range(0, 4)), 12'($urandom));
        end
        drain();
        force_rdy = 1'b1; rdy_val = 1'b1;

        // Reset during the second ACCESS cycle aborts the read.
        @(negedge clk);
        send(READ, RDR, 12'h000);
        @(negedge clk);
        @(negedge clk);
        chk(ssp_ssel == 1'b1, "abort_in_access", ssp_ssel, 1);
        rst_n = 1'b0;
        #1;
        chk({ssp_ssel, ssp_eoc, busy, rsp_valid} == 4'd0, "abort_outs",
            {ssp_ssel, ssp_eoc, busy, rsp_valid}, 0);
        sb.delete();
        n_aborted++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk(req_ready == 1'b1, "ready_after_abort", req_ready, 1);
        repeat (15) @(negedge clk);

        fast_test();

        chk(sb.size() == 0, "sb_empty", sb.size(), 0);
        chk(n_resp == n_issued - n_aborted, "rsp_count", n_resp, n_issued - n_aborted);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
